// File: rtl/sequential_signed_divider.sv
// sequential_signed_divider
//   Restoring shift/subtract signed divider producing one quotient bit per
//   clock. Operands are captured when start is seen in IDLE; the result is
//   registered in FIXUP together with a one-cycle done pulse.
//   Quotient truncates toward zero. The remainder takes the sign of the
//   dividend.
//
// Ports
//   sys_clk    in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   operation request, sampled only in IDLE
//   dividend   in   signed dividend (DIVIDEND_W)
//   divisor    in   signed divisor (DIVISOR_W)
//   busy       out  high while in LOAD, RUN or FIXUP
//   done       out  one-cycle pulse when results update
//   quotient   out  signed quotient (DIVIDEND_W)
//   remainder  out  signed remainder (DIVISOR_W)
//   div_zero   out  last operation divided by zero
//   overflow   out  last quotient was not representable (-2^(N-1) / -1)
//
// Build option
//   DIV_SATURATE_EN : on overflow the quotient saturates to 2^(N-1)-1
//                     instead of wrapping to -2^(N-1).

module sequential_signed_divider #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero,
  output logic                  overflow
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FIXUP = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Captured operands and sign record
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic                  sgn_n_q;
  logic                  sgn_d_q;
  logic                  dz_q;

  // Iteration state: quo_q starts as |dividend| and fills with quotient bits.
  // The partial remainder is always below |divisor| <= 2^(DIVISOR_W-1) after a
  // step, so DIVISOR_W bits hold it; the DIVISOR_W+1 bit value only exists
  // transiently as rem_shift.
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  dmag_q;
  logic [CNT_W-1:0]      cnt_q;

  // Output registers
  logic                  done_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  div_zero_q;
  logic                  overflow_q;

  // One restoring step
  logic [DIVISOR_W:0]    rem_shift;
  logic                  rem_ge;
  logic [DIVISOR_W:0]    rem_sub;
  logic [DIVISOR_W-1:0]  rem_step;
  logic [DIVIDEND_W-1:0] quo_step;

  // Sign fix-up
  logic                  q_neg;
  logic                  ovf_det;
  logic [DIVIDEND_W-1:0] quo_fix;
  logic [DIVISOR_W-1:0]  rem_fix;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = (dvs_q == '0) ? FIXUP : RUN;
      RUN:     if (cnt_q == CNT_ONE) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // ---------------------------------------------------------- datapath
  always_comb begin
    rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
    rem_ge    = (rem_shift >= {1'b0, dmag_q});
    rem_sub   = rem_shift - {1'b0, dmag_q};
    rem_step  = rem_ge ? rem_sub[DIVISOR_W-1:0] : rem_shift[DIVISOR_W-1:0];
    quo_step  = {quo_q[DIVIDEND_W-2:0], rem_ge};
  end

  // Only -2^(N-1) / -1 yields a positive quotient with the MSB of the
  // magnitude set; every other case fits.
  always_comb begin
    q_neg   = sgn_n_q ^ sgn_d_q;
    ovf_det = !dz_q && !q_neg && quo_q[DIVIDEND_W-1];
    quo_fix = q_neg ? -quo_q : quo_q;
    rem_fix = sgn_n_q ? -rem_q : rem_q;
    if (ovf_det) begin
`ifdef DIV_SATURATE_EN
      quo_fix = {1'b0, {(DIVIDEND_W-1){1'b1}}};
`else
      quo_fix = {1'b1, {(DIVIDEND_W-1){1'b0}}};
`endif
      rem_fix = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      sgn_n_q     <= 1'b0;
      sgn_d_q     <= 1'b0;
      dz_q        <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dmag_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
          end
        end
        LOAD: begin
          sgn_n_q <= dvd_q[DIVIDEND_W-1];
          sgn_d_q <= dvs_q[DIVISOR_W-1];
          dz_q    <= (dvs_q == '0);
          quo_q   <= dvd_q[DIVIDEND_W-1] ? -dvd_q : dvd_q;
          dmag_q  <= dvs_q[DIVISOR_W-1] ? -dvs_q : dvs_q;
          rem_q   <= '0;
          cnt_q   <= CNT_INIT;
        end
        RUN: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q - CNT_ONE;
        end
        FIXUP: begin
          done_q <= 1'b1;
          if (dz_q) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b1;
            overflow_q  <= 1'b0;
          end else begin
            quotient_q  <= quo_fix;
            remainder_q <= rem_fix;
            div_zero_q  <= 1'b0;
            overflow_q  <= ovf_det;
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sequential_signed_divider.sv
module tb_sequential_signed_divider;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  sequential_signed_divider #(
    .DIVIDEND_W(16),
    .DIVISOR_W (8)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

`ifdef DIV_SATURATE_EN
  localparam logic [15:0] OVF_Q = 16'h7FFF;
`else
  localparam logic [15:0] OVF_Q = 16'h8000;
`endif

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start one operation; lat is the number of edges after the capture edge
  // until done is seen (-1 if it never arrives within the bound).
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
    @(negedge sys_clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge sys_clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int done_seen;
    int first_done;

    vecs[0]  = '{"100/7",       16'd100,    8'd7,    16'h000E, 8'h02, 1'b0, 1'b0, 18};
    vecs[1]  = '{"-100/7",      16'hFF9C,   8'd7,    16'hFFF2, 8'hFE, 1'b0, 1'b0, 18};
    vecs[2]  = '{"100/-7",      16'd100,    8'hF9,   16'hFFF2, 8'h02, 1'b0, 1'b0, 18};
    vecs[3]  = '{"-100/-7",     16'hFF9C,   8'hF9,   16'h000E, 8'hFE, 1'b0, 1'b0, 18};
    vecs[4]  = '{"-32768/-128", 16'h8000,   8'h80,   16'h0100, 8'h00, 1'b0, 1'b0, 18};
    vecs[5]  = '{"-32768/1",    16'h8000,   8'h01,   16'h8000, 8'h00, 1'b0, 1'b0, 18};
    vecs[6]  = '{"-32768/-1",   16'h8000,   8'hFF,   OVF_Q,    8'h00, 1'b0, 1'b1, 18};
    vecs[7]  = '{"1234/0",      16'd1234,   8'h00,   16'h0000, 8'h00, 1'b1, 1'b0, 2};
    vecs[8]  = '{"32767/127",   16'h7FFF,   8'd127,  16'h0102, 8'h01, 1'b0, 1'b0, 18};
    vecs[9]  = '{"5/-128",      16'd5,      8'h80,   16'h0000, 8'h05, 1'b0, 1'b0, 18};
    vecs[10] = '{"-1/1",        16'hFFFF,   8'h01,   16'hFFFF, 8'h00, 1'b0, 1'b0, 18};
    vecs[11] = '{"-7/2",        16'hFFF9,   8'h02,   16'hFFFD, 8'hFF, 1'b0, 1'b0, 18};
    vecs[12] = '{"-5/0",        16'hFFFB,   8'h00,   16'h0000, 8'h00, 1'b1, 1'b0, 2};
    vecs[13] = '{"7/7",         16'd7,      8'd7,    16'h0001, 8'h00, 1'b0, 1'b0, 18};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("reset_busy",      {31'd0, busy},     32'd0);
    chk("reset_done",      {31'd0, done},     32'd0);
    chk("reset_quotient",  {16'd0, quotient}, 32'd0);
    chk("reset_remainder", {24'd0, remainder},32'd0);
    chk("reset_div_zero",  {31'd0, div_zero}, 32'd0);
    chk("reset_overflow",  {31'd0, overflow}, 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Table-driven operations
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk({vecs[i].name, "_latency"},  lat,                     vecs[i].lat);
      chk({vecs[i].name, "_quotient"}, {16'd0, quotient},       {16'd0, vecs[i].q});
      chk({vecs[i].name, "_remainder"},{24'd0, remainder},      {24'd0, vecs[i].r});
      chk({vecs[i].name, "_div_zero"}, {31'd0, div_zero},       {31'd0, vecs[i].dz});
      chk({vecs[i].name, "_overflow"}, {31'd0, overflow},       {31'd0, vecs[i].ov});
      @(posedge sys_clk);
      #1;
      chk({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({vecs[i].name, "_hold_q"},     {16'd0, quotient}, {16'd0, vecs[i].q});
    end

    // Second start during RUN is ignored; busy stays high mid-operation
    @(negedge sys_clk);
    dividend = 16'd500;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge sys_clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
      if (c == 4) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (c == 10) chk("midrun_busy", {31'd0, busy}, 32'd1);
    end
    chk("midrun_latency",   lat,                 18);
    chk("midrun_quotient",  {16'd0, quotient},   32'd166);
    chk("midrun_remainder", {24'd0, remainder},  32'd2);

    // start held high: next op begins on the first IDLE edge after done,
    // and results are not cleared by the new start
    @(negedge sys_clk);
    dividend = 16'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge sys_clk);
    first_done = -1;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge sys_clk);
      #1;
      if (first_done > 0 && c == first_done + 5)
        chk("held_result_kept", {16'd0, quotient}, 32'h000E);
      if (done) begin
        if (first_done < 0) begin
          first_done = c;
        end else begin
          lat = c;
          start = 1'b0;
          break;
        end
      end
    end
    chk("held_first_done",  first_done, 18);
    chk("held_second_done", lat,        37);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("held_idle_after", {31'd0, busy}, 32'd0);

    // Reset in the middle of RUN aborts without a done pulse
    @(negedge sys_clk);
    dividend = 16'd500;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    repeat (9) @(posedge sys_clk);
    #1;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",      {31'd0, busy},      32'd0);
    chk("abort_done",      {31'd0, done},      32'd0);
    chk("abort_quotient",  {16'd0, quotient},  32'd0);
    chk("abort_remainder", {24'd0, remainder}, 32'd0);
    chk("abort_div_zero",  {31'd0, div_zero},  32'd0);
    chk("abort_overflow",  {31'd0, overflow},  32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge sys_clk);
      #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
